// File: rtl/calendar_counter.sv
// Day/month/year calendar counter for the digital clock.
// Advances one day per tick (midnight carry from the time-of-day chain). Month lengths are
// either Gregorian with leap years (FIXED_DAYS = 0) or a single fixed length for every month.
// A parallel load is validated against the loaded month/year before it is accepted.
//
// Ports:
//   clk          rising-edge clock
//   clear_n      asynchronous active-low reset (state -> 1/1/0, pulses cleared)
//   tick         advance one day (single-cycle pulse)
//   load         parallel load request, takes priority over tick (a coincident tick is dropped)
//   ld_day       day to load, 1-based
//   ld_month     month to load, 1..12
//   ld_year      year offset to load
//   enable       gates databus only; never stalls counting
//   day          current day, 1-based
//   month        current month, 1..12
//   year         current year offset from BASE_YEAR
//   month_carry  1-cycle pulse: month rolled over
//   year_carry   1-cycle pulse: year rolled over
//   year_wrap    1-cycle pulse: year offset wrapped from max to 0
//   load_err     1-cycle pulse: load rejected, state held
//   databus      {year, month, day} when enable, else zero
module calendar_counter #(
  parameter int unsigned YEAR_W     = 7,
  parameter int unsigned BASE_YEAR  = 2000,
  parameter int unsigned FIXED_DAYS = 0
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              tick,
  input  logic              load,
  input  logic [4:0]        ld_day,
  input  logic [3:0]        ld_month,
  input  logic [YEAR_W-1:0] ld_year,
  input  logic              enable,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              month_carry,
  output logic              year_carry,
  output logic              year_wrap,
  output logic              load_err,
  output logic [8+YEAR_W:0] databus
);

  // Length of month m in year offset y.
  function automatic logic [4:0] days_in(input logic [3:0] m, input logic [YEAR_W-1:0] y);
    int unsigned yr;
    logic        leap;
    logic [4:0]  len;
    yr   = BASE_YEAR + 32'(y);
    leap = (((yr % 4) == 0) && ((yr % 100) != 0)) || ((yr % 400) == 0);
    if (FIXED_DAYS != 0) begin
      len = 5'(FIXED_DAYS);
    end else begin
      case (m)
        4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
        4'd2:                    len = leap ? 5'd29 : 5'd28;
        default:                 len = 5'd31;
      endcase
    end
    return len;
  endfunction

  logic [4:0]        day_q, day_d;
  logic [3:0]        month_q, month_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic              month_carry_q, month_carry_d;
  logic              year_carry_q, year_carry_d;
  logic              year_wrap_q, year_wrap_d;
  logic              load_err_q, load_err_d;

  logic [4:0] cur_len;
  logic [4:0] ld_len;
  logic       ld_ok;

  always_comb begin
    cur_len = days_in(month_q, year_q);
    ld_len  = days_in(ld_month, ld_year);
    ld_ok   = (ld_month >= 4'd1) && (ld_month <= 4'd12) &&
              (ld_day >= 5'd1) && (ld_day <= ld_len);
  end

  always_comb begin
    day_d         = day_q;
    month_d       = month_q;
    year_d        = year_q;
    month_carry_d = 1'b0;
    year_carry_d  = 1'b0;
    year_wrap_d   = 1'b0;
    load_err_d    = 1'b0;
    if (load) begin
      if (ld_ok) begin
        day_d   = ld_day;
        month_d = ld_month;
        year_d  = ld_year;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick) begin
      if (day_q < cur_len) begin
        day_d = day_q + 5'd1;
      end else begin
        // >= rather than == so a forced out-of-range day still rolls the month.
        day_d         = 5'd1;
        month_carry_d = 1'b1;
        if (month_q >= 4'd12) begin
          month_d      = 4'd1;
          year_carry_d = 1'b1;
          year_d       = year_q + 1'b1;
          year_wrap_d  = &year_q;
        end else begin
          month_d = month_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      day_q         <= 5'd1;
      month_q       <= 4'd1;
      year_q        <= '0;
      month_carry_q <= 1'b0;
      year_carry_q  <= 1'b0;
      year_wrap_q   <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      day_q         <= day_d;
      month_q       <= month_d;
      year_q        <= year_d;
      month_carry_q <= month_carry_d;
      year_carry_q  <= year_carry_d;
      year_wrap_q   <= year_wrap_d;
      load_err_q    <= load_err_d;
    end
  end

  assign day         = day_q;
  assign month       = month_q;
  assign year        = year_q;
  assign month_carry = month_carry_q;
  assign year_carry  = year_carry_q;
  assign year_wrap   = year_wrap_q;
  assign load_err    = load_err_q;
  assign databus     = enable ? {year_q, month_q, day_q} : '0;

endmodule

// File: tb/tb_calendar_counter.sv
module tb_calendar_counter;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        tick;
  logic        load;
  logic [4:0]  ld_day;
  logic [3:0]  ld_month;
  logic [6:0]  ld_year;
  logic        enable;

  // Gregorian instance
  logic [4:0]  day;
  logic [3:0]  month;
  logic [6:0]  year;
  logic        month_carry, year_carry, year_wrap, load_err;
  logic [15:0] databus;

  // Fixed 30-day instance, same stimulus
  logic [4:0]  f_day;
  logic [3:0]  f_month;
  logic [6:0]  f_year;
  logic        f_month_carry, f_year_carry, f_year_wrap, f_load_err;
  logic [15:0] f_databus;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  calendar_counter #(.YEAR_W(7), .BASE_YEAR(2000), .FIXED_DAYS(0)) u_dut (
    .clk(clk), .clear_n(clear_n), .tick(tick), .load(load),
    .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year), .enable(enable),
    .day(day), .month(month), .year(year),
    .month_carry(month_carry), .year_carry(year_carry), .year_wrap(year_wrap),
    .load_err(load_err), .databus(databus)
  );

  calendar_counter #(.YEAR_W(7), .BASE_YEAR(2000), .FIXED_DAYS(30)) u_fix (
    .clk(clk), .clear_n(clear_n), .tick(tick), .load(load),
    .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year), .enable(enable),
    .day(f_day), .month(f_month), .year(f_year),
    .month_carry(f_month_carry), .year_carry(f_year_carry), .year_wrap(f_year_wrap),
    .load_err(f_load_err), .databus(f_databus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: present inputs after the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic ld, input int d, input int m, input int y, input logic tk);
    @(negedge clk);
    load     = ld;
    ld_day   = 5'(d);
    ld_month = 4'(m);
    ld_year  = 7'(y);
    tick     = tk;
    @(posedge clk);
    #1;
    load = 1'b0;
    tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_n = 1'b0;
    #2;
    clear_n = 1'b1;
  endtask

  initial begin
    clear_n  = 1'b0;
    tick     = 1'b0;
    load     = 1'b0;
    ld_day   = '0;
    ld_month = '0;
    ld_year  = '0;
    enable   = 1'b0;
    #12;

    // Reset state and bus gating
    chk("rst_day", day, 1);
    chk("rst_month", month, 1);
    chk("rst_year", year, 0);
    chk("rst_pulses", {month_carry, year_carry, year_wrap, load_err}, 0);
    chk("bus_off", databus, 0);
    enable = 1'b1;
    #1;
    chk("bus_on", databus, 16'h0021);
    @(negedge clk);
    clear_n = 1'b1;

    // Leap year 2024
    step(1, 28, 2, 24, 0);
    chk("ld_2024_bus", databus, {7'd24, 4'd2, 5'd28});
    chk("ld_2024_err", load_err, 0);
    step(0, 0, 0, 0, 1);
    chk("feb29_day", day, 29);
    chk("feb29_mc", month_carry, 0);
    step(0, 0, 0, 0, 1);
    chk("mar1_bus", databus, {7'd24, 4'd3, 5'd1});
    chk("mar1_mc", month_carry, 1);
    step(0, 0, 0, 0, 0);
    chk("mar1_mc_drop", month_carry, 0);
    chk("hold_bus", databus, {7'd24, 4'd3, 5'd1});

    // 2100 is not leap
    step(1, 28, 2, 100, 0);
    step(0, 0, 0, 0, 1);
    chk("y2100_bus", databus, {7'd100, 4'd3, 5'd1});
    chk("y2100_mc", month_carry, 1);
    step(1, 29, 2, 100, 0);
    chk("y2100_err", load_err, 1);
    chk("y2100_hold", databus, {7'd100, 4'd3, 5'd1});
    step(0, 0, 0, 0, 0);
    chk("y2100_err_drop", load_err, 0);

    // 2000 is leap (divisible by 400)
    step(1, 29, 2, 0, 0);
    chk("y2000_ok", {load_err, databus}, {1'b0, 7'd0, 4'd2, 5'd29});

    // Bad month / day zero / 31 April
    step(1, 1, 13, 3, 0);
    chk("ld_m13_err", load_err, 1);
    step(1, 0, 5, 3, 0);
    chk("ld_d0_err", load_err, 1);
    step(1, 31, 4, 3, 0);
    chk("ld_apr31_err", {load_err, databus}, {1'b1, 7'd0, 4'd2, 5'd29});

    // 30 April rolls to 1 May
    step(1, 30, 4, 5, 0);
    step(0, 0, 0, 0, 1);
    chk("apr30_tick", {month_carry, year_carry, databus}, {2'b10, 7'd5, 4'd5, 5'd1});

    // Year carry without wrap
    step(1, 31, 12, 5, 0);
    step(0, 0, 0, 0, 1);
    chk("dec31_bus", databus, {7'd6, 4'd1, 5'd1});
    chk("dec31_pulses", {month_carry, year_carry, year_wrap}, 3'b110);

    // Year wrap
    step(1, 31, 12, 127, 0);
    step(0, 0, 0, 0, 1);
    chk("wrap_bus", databus, {7'd0, 4'd1, 5'd1});
    chk("wrap_pulses", {month_carry, year_carry, year_wrap}, 3'b111);
    step(0, 0, 0, 0, 0);
    chk("wrap_pulses_drop", {month_carry, year_carry, year_wrap}, 3'b000);

    // Load and tick together: tick dropped
    step(1, 15, 6, 5, 1);
    chk("ldtick_bus", databus, {7'd5, 4'd6, 5'd15});
    chk("ldtick_mc", month_carry, 0);
    step(0, 0, 0, 0, 1);
    chk("after_ldtick", day, 16);

    // Async reset mid-cycle
    @(posedge clk);
    #3;
    clear_n = 1'b0;
    #1;
    chk("async_rst_bus", databus, {7'd0, 4'd1, 5'd1});
    @(negedge clk);
    clear_n = 1'b1;

    // Fixed 30-day mode
    step(1, 30, 1, 0, 0);
    chk("fix_ld30", {f_load_err, f_day, f_month}, {1'b0, 5'd30, 4'd1});
    step(0, 0, 0, 0, 1);
    chk("fix_tick", {f_month_carry, f_databus}, {1'b1, 7'd0, 4'd2, 5'd1});
    step(1, 31, 1, 0, 0);
    chk("fix_ld31_err", {f_load_err, f_databus}, {1'b1, 7'd0, 4'd2, 5'd1});
    chk("greg_ld31_ok", {load_err, databus}, {1'b0, 7'd0, 4'd1, 5'd31});
    step(1, 30, 2, 0, 0);
    chk("fix_feb30_ok", {f_load_err, f_day, f_month}, {1'b0, 5'd30, 4'd2});
    chk("greg_feb30_err", load_err, 1);
    step(1, 5, 13, 0, 0);
    chk("fix_m13_err", f_load_err, 1);

    // 360 back-to-back ticks from 1/1/0
    do_reset();
    @(negedge clk);
    tick = 1'b1;
    repeat (360) @(posedge clk);
    #1;
    tick = 1'b0;
    chk("fix_360_bus", f_databus, {7'd1, 4'd1, 5'd1});
    chk("fix_360_yc", {f_month_carry, f_year_carry, f_year_wrap}, 3'b110);
    // 2000: Jan31 Feb29 Mar31 Apr30 Mai31 Jun30 Jul31 Aug31 Sep30 Oct31 Nov30 = 335 -> Dec 1, +25 = Dec 26
    chk("greg_360_bus", databus, {7'd0, 4'd12, 5'd26});

    enable = 1'b0;
    #1;
    chk("bus_gated", {databus, f_databus}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
